// File: rtl/pixel_plot_arbiter.sv
// Merges two pixel streams (paddle on A, ball on B) into one VGA write port.
// Each port buffers into its own small FIFO; a round-robin arbiter drains one pixel per cycle.
module pixel_plot_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned X_MAX      = 160,
  parameter int unsigned Y_MAX      = 120
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       a_plot,
  input  logic [7:0] a_x,
  input  logic [7:0] a_y,
  input  logic [2:0] a_colour,
  input  logic       b_plot,
  input  logic [7:0] b_x,
  input  logic [7:0] b_y,
  input  logic [2:0] b_colour,
  input  logic       clear_flags,
  output logic       out_plot,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [2:0] out_colour,
  output logic       a_overflow,
  output logic       b_overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [18:0]   din [2];
  logic [1:0]    plot_in, in_rng, full, push, pop, drop;
  logic          sel;
  logic [18:0]   pop_pix;

  logic [18:0]   mem_q [2][FIFO_DEPTH];
  logic [18:0]   mem_d [2][FIFO_DEPTH];
  logic [PW-1:0] wr_q [2];
  logic [PW-1:0] wr_d [2];
  logic [PW-1:0] rd_q [2];
  logic [PW-1:0] rd_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic          last_b_q, last_b_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          out_plot_q, out_plot_d;
  logic [18:0]   out_pix_q, out_pix_d;

  assign din[0]    = {a_x, a_y, a_colour};
  assign din[1]    = {b_x, b_y, b_colour};
  assign plot_in   = {b_plot, a_plot};
  assign in_rng[0] = (32'(a_x) < X_MAX) && (32'(a_y) < Y_MAX);
  assign in_rng[1] = (32'(b_x) < X_MAX) && (32'(b_y) < Y_MAX);

  always_comb begin
    // Grant uses pre-edge occupancy; last_b_q=1 means B was served last, so A wins a tie.
    pop[0]  = (cnt_q[0] != '0) && ((cnt_q[1] == '0) || last_b_q);
    pop[1]  = (cnt_q[1] != '0) && !pop[0];
    sel     = pop[1];
    pop_pix = mem_q[sel][rd_q[sel]];

    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      full[i]  = (cnt_q[i] == FULL);
      // A slot freed by this edge's pop lets a full FIFO still accept.
      push[i]  = plot_in[i] && in_rng[i] && (!full[i] || pop[i]);
      drop[i]  = plot_in[i] && in_rng[i] && full[i] && !pop[i];
      wr_d[i]  = push[i] ? wr_q[i] + PW'(1) : wr_q[i];
      rd_d[i]  = pop[i]  ? rd_q[i] + PW'(1) : rd_q[i];
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      ovf_d[i] = drop[i] | (ovf_q[i] & ~clear_flags);
      if (push[i]) mem_d[i][wr_q[i]] = din[i];
    end

    last_b_d   = pop[1] ? 1'b1 : (pop[0] ? 1'b0 : last_b_q);
    out_plot_d = |pop;
    out_pix_d  = (|pop) ? pop_pix : out_pix_q;
  end

  always_ff @(posedge CLOCK_50) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      last_b_q   <= 1'b1;
      ovf_q      <= '0;
      out_plot_q <= 1'b0;
      out_pix_q  <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      ovf_q      <= ovf_d;
      out_plot_q <= out_plot_d;
      out_pix_q  <= out_pix_d;
    end
  end

  assign out_plot   = out_plot_q;
  assign out_x      = out_pix_q[18:11];
  assign out_y      = out_pix_q[10:3];
  assign out_colour = out_pix_q[2:0];
  assign a_overflow = ovf_q[0];
  assign b_overflow = ovf_q[1];

endmodule

// File: doc/pixel_plot_arbiter.md
PIXEL_PLOT_ARBITER -- requirements
Module: pixel_plot_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries per input FIFO; power of two, 2..16.
REQ-002 Parameter X_MAX, default 160: first out-of-range x.
REQ-003 Parameter Y_MAX, default 120: first out-of-range y.
REQ-004 CLOCK_50  input  1  system clock; all state updates on posedge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 a_plot  input  1  port A pixel valid (paddle source); no backpressure.
REQ-007 a_x  input  8  port A pixel x.
REQ-008 a_y  input  8  port A pixel y.
REQ-009 a_colour  input  3  port A pixel colour.
REQ-010 b_plot, b_x, b_y, b_colour  input  1/8/8/3  port B pixel stream (ball source), same meaning as port A.
REQ-011 clear_flags  input  1  clears sticky overflow flags.
REQ-012 out_plot  output  1  registered write strobe to the VGA adapter.
REQ-013 out_x, out_y  output  8/8  registered pixel coordinates.
REQ-014 out_colour  output  3  registered pixel colour.
REQ-015 a_overflow, b_overflow  output  1/1  sticky flags: a pixel was dropped because its FIFO was full.

Function
REQ-016 Each port SHALL feed its own FIFO_DEPTH x 19-bit FIFO holding {x, y, colour}.
REQ-017 A port SHALL push on a posedge only when: plot=1, x<X_MAX, y<Y_MAX, and the FIFO is not full (space freed by a same-edge pop counts as not full).
REQ-018 An out-of-range pixel SHALL be silently discarded and SHALL NOT set overflow.
REQ-019 An in-range pixel arriving at a full FIFO with no same-edge pop SHALL be discarded and SHALL set that port's overflow flag on that edge.
REQ-020 On each posedge the arbiter SHALL pop at most one entry in total, choosing from FIFO occupancy as it stood before the edge.
REQ-021 The arbiter SHALL use round-robin: with both FIFOs non-empty, the port not granted last wins; with one non-empty, that port wins.
REQ-022 The last-grant register SHALL update only on an actual pop.
REQ-023 On a pop, out_x/out_y/out_colour SHALL load the popped entry and out_plot SHALL be 1 for exactly that cycle.
REQ-024 With no pop, out_plot SHALL be 0 and out_x/out_y/out_colour SHALL hold their previous values.
REQ-025 Latency: a pixel pushed at edge E into an empty FIFO that wins arbitration SHALL appear on out_* after edge E+1.
REQ-026 Ordering within a port SHALL be preserved; the two ports SHALL have no ordering relation.
REQ-027 Sustained throughput SHALL be one pixel per cycle total; simultaneous pushes from A and B SHALL both be accepted while space exists.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a log2(FIFO_DEPTH)+1-bit count so full and empty are unambiguous.
REQ-029 clear_flags=1 SHALL clear both overflow flags at the edge, except that a same-edge overflow event SHALL set its flag (set wins).

Reset
REQ-030 While reset_n=0 at a posedge, the block SHALL set out_plot=0, out_x=0, out_y=0, out_colour=0, both FIFOs empty, both overflow flags 0, and last-grant=B (so A wins the first tie).
REQ-031 Reset asserted mid-operation SHALL discard all buffered pixels, and input strobes present on that edge SHALL be ignored.
REQ-032 The first push SHALL be accepted on the first posedge with reset_n=1.

Verification
REQ-033 Single A pixel (x=5, y=110, c=7) at edge 1 after reset -> out_plot=1 with (5,110,7) after edge 2 only; out_plot=0 thereafter.
REQ-034 A and B both plotting every cycle for 8 cycles, with all FIFOs empty at start -> outputs alternate A,B,A,B...; A first; no overflow until an occupancy exceeds FIFO_DEPTH.
REQ-035 A streams 4 pixels x=0,1,2,3 with B idle -> out_x 0,1,2,3 on consecutive cycles; B silent.
REQ-036 Pixel x=160, y=10 on A, then x=10, y=120 on B -> no out_plot; overflow flags stay 0.
REQ-037 Fill B to 4 entries while A also pushes each cycle, then one more B pixel -> b_overflow=1 and that pixel never appears; clear_flags -> b_overflow=0 next cycle unless a new drop occurs on that edge.
REQ-038 reset_n=0 for one edge with both FIFOs holding 3 entries -> out_plot=0 after that edge and no buffered pixel is ever emitted; A wins the next tie.
